// File: rtl/uart_tx_fifo_if.sv
// Write port of the UART transmitter: a producer pushes words into the TX FIFO.
// Handshake: a word transfers on a rising clk edge where tx_data_valid=1 and tx_ready=1.
// A valid word presented while tx_ready=0 is dropped, not held; the slave flags it on overflow.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_data_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_data_valid, output tx_data, input tx_ready);
   modport slave  (input tx_data_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits; back-to-back frames go out with no idle gap when words are queued.
module uart_tx_fifo #(
   parameter int    CLOCK_FREQ = 50_000_000,
   parameter int    BAUD_RATE  = 115_200,
   parameter int    DATA_BITS  = 8,
   parameter string PARITY     = "NONE",
   parameter int    STOP_BITS  = 1,
   parameter int    FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   uart_tx_fifo_if.slave               wr,
   output logic                        tx_out,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 frame_count,
   output logic [2:0]                  state_dbg
);
   localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int LVL_W    = PTR_W + 1;
   localparam bit HAS_PAR  = (PARITY != "NONE");
   localparam bit PAR_ODD  = (PARITY == "ODD");

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 overflow_q, overflow_d;
   logic [15:0]          count_q, count_d;
   logic                 push, pop, full, empty, baud_end, stop_end;
   logic [DATA_BITS-1:0] head;

   state_e               state_q;
   logic [CNT_W-1:0]     baud_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q, tx_out_q, tx_busy_q, tx_done_q;

   // Ready depends on the stored level only, so a pop in the same cycle never rescues a full FIFO.
   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty    = (level_q == '0);
   assign head     = mem_q[rd_ptr_q];
   assign baud_end = (baud_q == CNT_W'(BAUD_DIV - 1));
   assign stop_end = (state_q == S_STOP) && baud_end && (bit_q == 4'(STOP_BITS - 1));
   assign push     = wr.tx_data_valid && !full;
   assign pop      = !empty && ((state_q == S_IDLE) || stop_end);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      level_d    = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
      overflow_d = wr.tx_data_valid && full;
      count_d    = count_q + 16'(stop_end);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr.tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_out_q  <= 1'b1;
         tx_busy_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         case (state_q)
            S_START: begin
               if (baud_end) begin
                  state_q  <= S_DATA;
                  baud_q   <= '0;
                  bit_q    <= '0;
                  tx_out_q <= shift_q[0];
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     bit_q <= '0;
                     if (HAS_PAR) begin
                        state_q  <= S_PARITY;
                        tx_out_q <= par_q;
                     end else begin
                        state_q  <= S_STOP;
                        tx_out_q <= 1'b1;
                     end
                  end else begin
                     bit_q    <= bit_q + 4'd1;
                     shift_q  <= shift_q >> 1;
                     tx_out_q <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            S_PARITY: begin
               if (baud_end) begin
                  state_q  <= S_STOP;
                  baud_q   <= '0;
                  bit_q    <= '0;
                  tx_out_q <= 1'b1;
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (stop_end) begin
                  tx_done_q <= 1'b1;
                  state_q   <= S_IDLE;
                  tx_busy_q <= 1'b0;
               end else if (baud_end) begin
                  baud_q <= '0;
                  bit_q  <= bit_q + 4'd1;
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
         // A pop (from IDLE or the last stop-bit edge) overrides the above and starts a new frame.
         if (pop) begin
            state_q   <= S_START;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= head;
            par_q     <= (^head) ^ PAR_ODD;
            tx_out_q  <= 1'b0;
            tx_busy_q <= 1'b1;
         end
      end
   end

   assign wr.tx_ready = !full;
   assign tx_out      = tx_out_q;
   assign tx_busy     = tx_busy_q;
   assign tx_done     = tx_done_q;
   assign overflow    = overflow_q;
   assign fifo_level  = level_q;
   assign frame_count = count_q;
   assign state_dbg   = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 8E2, 7O1) driven side by side and
// compared every cycle against a frame-timeline reference model.
module tb_uart_tx_fifo;
   localparam int NI       = 3;
   localparam int BAUD_DIV = 10;
   localparam int DEPTH    = 4;
   localparam int CFG_BITS [NI] = '{8, 8, 7};
   localparam int CFG_PAR  [NI] = '{0, 2, 1};   // 0 none, 1 odd, 2 even
   localparam int CFG_STOP [NI] = '{1, 2, 1};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        vld      [NI];
   logic [8:0]  dat      [NI];
   logic        tx_out_w [NI];
   logic        busy_w   [NI];
   logic        done_w   [NI];
   logic        ovf_w    [NI];
   logic        ready_w  [NI];
   logic [2:0]  lvl_w    [NI];
   logic [2:0]  dbg_w    [NI];
   logic [15:0] cnt_w    [NI];
   string       nm       [NI] = '{"8n1", "8e2", "7o1"};

   uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
   uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if_c ();

   assign if_a.tx_data_valid = vld[0];
   assign if_a.tx_data       = dat[0][7:0];
   assign ready_w[0]         = if_a.tx_ready;
   assign if_b.tx_data_valid = vld[1];
   assign if_b.tx_data       = dat[1][7:0];
   assign ready_w[1]         = if_b.tx_ready;
   assign if_c.tx_data_valid = vld[2];
   assign if_c.tx_data       = dat[2][6:0];
   assign ready_w[2]         = if_c.tx_ready;

   uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY("NONE"),
                  .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
      .clk(clk), .rst_n(rst_n), .wr(if_a), .tx_out(tx_out_w[0]), .tx_busy(busy_w[0]),
      .tx_done(done_w[0]), .overflow(ovf_w[0]), .fifo_level(lvl_w[0]),
      .frame_count(cnt_w[0]), .state_dbg(dbg_w[0]));

   uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY("EVEN"),
                  .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
      .clk(clk), .rst_n(rst_n), .wr(if_b), .tx_out(tx_out_w[1]), .tx_busy(busy_w[1]),
      .tx_done(done_w[1]), .overflow(ovf_w[1]), .fifo_level(lvl_w[1]),
      .frame_count(cnt_w[1]), .state_dbg(dbg_w[1]));

   uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY("ODD"),
                  .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_c (
      .clk(clk), .rst_n(rst_n), .wr(if_c), .tx_out(tx_out_w[2]), .tx_busy(busy_w[2]),
      .tx_done(done_w[2]), .overflow(ovf_w[2]), .fifo_level(lvl_w[2]),
      .frame_count(cnt_w[2]), .state_dbg(dbg_w[2]));

   // ---------------- scoreboard / reference model ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  exp_q0[$], exp_q1[$], exp_q2[$];
   int          m_level [NI];
   int          m_left  [NI];   // cycles left in the frame on the line, 0 = idle
   logic [15:0] m_bits  [NI];   // line level per bit slot of the current frame
   logic        m_ovf   [NI];
   logic        m_done  [NI];
   logic [15:0] m_count [NI];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [8:0] mask_of(input int i);
      return 9'((1 << CFG_BITS[i]) - 1);
   endfunction

   function automatic int frame_len(input int i);
      return (1 + CFG_BITS[i] + ((CFG_PAR[i] != 0) ? 1 : 0) + CFG_STOP[i]) * BAUD_DIV;
   endfunction

   function automatic logic [15:0] frame_bits(input int i, input logic [8:0] w);
      logic [15:0] b;
      int n;
      b    = '1;
      b[0] = 1'b0;
      for (int k = 0; k < CFG_BITS[i]; k++) b[1 + k] = w[k];
      n = 1 + CFG_BITS[i];
      if (CFG_PAR[i] != 0) b[n] = (^(w & mask_of(i))) ^ (CFG_PAR[i] == 1);
      return b;
   endfunction

   task automatic q_push(input int i, input logic [8:0] d);
      case (i)
         0: exp_q0.push_back(d);
         1: exp_q1.push_back(d);
         default: exp_q2.push_back(d);
      endcase
   endtask

   task automatic q_pop(input int i, output logic [8:0] d);
      case (i)
         0: d = exp_q0.pop_front();
         1: d = exp_q1.pop_front();
         default: d = exp_q2.pop_front();
      endcase
   endtask

   task automatic model_reset();
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
      for (int i = 0; i < NI; i++) begin
         m_level[i] = 0; m_left[i] = 0; m_bits[i] = '1;
         m_ovf[i] = 1'b0; m_done[i] = 1'b0; m_count[i] = '0;
      end
   endtask

   // One clock edge: a frame ends after frame_len cycles; the next queued word starts on
   // that same edge (or on the first edge while idle); writes land only when not full.
   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         int lvl, bl;
         bit pop, acc;
         logic [8:0] w;
         lvl = m_level[i];
         bl  = m_left[i];
         m_done[i] = (bl == 1);
         pop = (lvl > 0) && (bl <= 1);
         acc = vld[i] && (lvl < DEPTH);
         m_ovf[i] = vld[i] && !acc;
         if (bl > 0) bl--;
         if (m_done[i]) m_count[i]++;
         if (pop) begin
            q_pop(i, w);
            m_bits[i] = frame_bits(i, w);
            bl = frame_len(i);
         end
         if (acc) q_push(i, dat[i] & mask_of(i));
         m_level[i] = lvl + int'(acc) - int'(pop);
         m_left[i]  = bl;
      end
   endtask

   function automatic logic exp_line(input int i);
      if (m_left[i] == 0) return 1'b1;
      return m_bits[i][(frame_len(i) - m_left[i]) / BAUD_DIV];
   endfunction

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s line", nm[i]),  tx_out_w[i], exp_line(i));
         check($sformatf("%s busy", nm[i]),  busy_w[i],   m_left[i] > 0);
         check($sformatf("%s done", nm[i]),  done_w[i],   m_done[i]);
         check($sformatf("%s ovf", nm[i]),   ovf_w[i],    m_ovf[i]);
         check($sformatf("%s ready", nm[i]), ready_w[i],  m_level[i] < DEPTH);
         check($sformatf("%s level", nm[i]), lvl_w[i],    m_level[i]);
         check($sformatf("%s count", nm[i]), cnt_w[i],    m_count[i]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic drive(input int i, input logic v, input logic [8:0] d);
      vld[i] = v;
      dat[i] = d;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NI; i++) vld[i] = 1'b0;
   endtask

   initial begin
      int c0;
      int pct;
      for (int i = 0; i < NI; i++) drive(i, 1'b0, '0);
      model_reset();
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(2);

      // One frame per configuration: 0x55 8N1, 0x07 8E2, 0x00 7O1
      drive(0, 1'b1, 9'h055); drive(1, 1'b1, 9'h007); drive(2, 1'b1, 9'h000);
      tick();
      idle_all();
      run(125);
      check("8n1 frames", cnt_w[0], 1);
      check("8e2 frames", cnt_w[1], 1);
      check("7o1 frames", cnt_w[2], 1);

      // Overflow: busy with empty FIFO, then five back-to-back writes
      drive(0, 1'b1, 9'($urandom_range(0, 255)));
      tick();
      idle_all();
      run(2);
      for (int k = 0; k < 5; k++) begin
         drive(0, 1'b1, 9'($urandom_range(0, 255)));
         tick();
      end
      check("full ovf", ovf_w[0], 1);
      check("full level", lvl_w[0], 4);
      check("full ready", ready_w[0], 0);
      idle_all();
      tick();
      check("ovf pulse", ovf_w[0], 0);
      run(560);

      // Back-to-back frames 0xA5 then 0x3C
      c0 = int'(cnt_w[0]);
      drive(0, 1'b1, 9'h0A5); tick();
      drive(0, 1'b1, 9'h03C); tick();
      idle_all();
      run(205);
      check("b2b frames", cnt_w[0], 32'(c0 + 2));

      // Asynchronous reset in the middle of the DATA phase with three words queued
      drive(0, 1'b1, 9'($urandom_range(0, 255)));
      tick();
      idle_all();
      run(25);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1'b1, 9'($urandom_range(0, 255)));
         tick();
      end
      idle_all();
      check("pre-rst level", lvl_w[0], 3);
      #2 rst_n = 1'b0;
      #1;
      check("async line", tx_out_w[0], 1);
      check("async level", lvl_w[0], 0);
      check("async busy", busy_w[0], 0);
      check("async ready", ready_w[0], 1);
      check("async count", cnt_w[0], 0);
      model_reset();
      run(3);
      rst_n = 1'b1;
      run(300);

      // Randomized traffic with phases of varying write pressure
      for (int ph = 0; ph < 6; ph++) begin
         pct = (ph % 2 == 0) ? $urandom_range(40, 95) : $urandom_range(1, 8);
         repeat (500) begin
            for (int i = 0; i < NI; i++)
               drive(i, 1'($urandom_range(0, 99) < pct), 9'($urandom_range(0, 511)));
            tick();
         end
      end
      idle_all();
      run(700);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame.
REQ-004 SHALL have parameter PARITY, default "NONE", legal values "NONE"/"ODD"/"EVEN".
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port tx_data_valid  input  1  write request.
REQ-010 SHALL have port tx_data  input  DATA_BITS  write payload.
REQ-011 SHALL have port tx_ready  output  1  FIFO can accept a word (not full).
REQ-012 SHALL have port tx_out  output  1  serial line, idle high, registered.
REQ-013 SHALL have port tx_busy  output  1  frame in progress.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at frame end.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse on dropped write.
REQ-016 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  words stored.
REQ-017 SHALL have port frame_count  output  16  frames completed, wraps 0xFFFF->0x0000.

Function
REQ-018 Bit period SHALL be BAUD_DIV = CLOCK_FREQ/BAUD_RATE (integer truncation) clocks for every bit.
REQ-019 Write SHALL be accepted on a rising edge with tx_data_valid=1 and tx_ready=1; tx_ready SHALL be 0 exactly when fifo_level==FIFO_DEPTH.
REQ-020 Write with tx_data_valid=1 and tx_ready=0 SHALL be dropped and SHALL raise overflow for the following cycle only; a same-cycle pop SHALL NOT make a full FIFO accept.
REQ-021 fifo_level SHALL: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-022 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE with FIFO non-empty SHALL pop the head word and enter START at the same edge; tx_out low from that edge (start bit begins one cycle after a write into an empty FIFO with FSM idle).
REQ-024 START SHALL last one bit period then enter DATA; DATA SHALL send DATA_BITS bits LSB first.
REQ-025 After DATA, SHALL enter PARITY when PARITY!="NONE", else STOP; parity bit SHALL be XOR of data for "EVEN", inverted XOR for "ODD".
REQ-026 STOP SHALL drive tx_out high for STOP_BITS bit periods.
REQ-027 At end of STOP, tx_done SHALL pulse one cycle and frame_count SHALL increment; if FIFO non-empty, SHALL pop and enter START at that same edge (zero idle cycles), else enter IDLE.
REQ-028 tx_busy SHALL be 1 in every state except IDLE; tx_out SHALL be 1 in IDLE.
REQ-029 FIFO SHALL preserve order; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 rst_n low SHALL immediately force tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, overflow=0, fifo_level=0, frame_count=0, FSM=IDLE, FIFO empty.
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard all queued words; after release the line SHALL stay high until a new write.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, BAUD_DIV=10 unless stated)
REQ-032 8N1, write 0x55 into idle block -> start low 10 cycles from next edge, data 1,0,1,0,1,0,1,0 at 10 cycles each, stop high 10 cycles, tx_done at cycle 100 after start edge, frame_count=1.
REQ-033 PARITY="EVEN", STOP_BITS=2, write 0x07 -> parity bit 1, stop high 20 cycles, frame 120 cycles.
REQ-034 PARITY="ODD", DATA_BITS=7, write 0x00 -> 7 zero data bits then parity bit 1, frame 100 cycles.
REQ-035 FIFO_DEPTH=4, tx_busy=1, FIFO empty, 5 writes on consecutive cycles -> first 4 accepted, fifo_level=4, tx_ready=0, 5th dropped with overflow=1 for one cycle.
REQ-036 Queue 0xA5 then 0x3C -> second start bit immediately follows first stop bit, no idle cycle, frame_count=2, bytes in order.
REQ-037 rst_n low during DATA with 3 words queued -> tx_out=1 without waiting for clk, fifo_level=0; after release tx_out stays 1, no frame sent.
